// File: rtl/alu_seq_pkg.sv
// Shared types and configuration helpers for the slice-serial wide adder.
package alu_seq_pkg;

    localparam int DEF_WIDTH = 128;
    localparam int DEF_SLICE = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // True when WIDTH splits into at least two equal slices.
    function automatic bit slicing_ok(input int width, input int slice);
        return ((width % slice) == 0) && ((width / slice) >= 2);
    endfunction

endpackage

// File: rtl/full_adder_32bit.sv
// Shared SLICE-bit ripple adder with optional B inversion; also exposes the
// carry into the MSB so the caller can derive signed overflow.
module full_adder_32bit #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         invert_b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         c_msb
);

    logic [W-1:0] b_eff_s;
    logic [W:0]   chain_s;

    assign b_eff_s = invert_b ? ~b : b;

    // Bit-serial carry chain across the slice.
    always_comb begin
        chain_s    = '0;
        sum        = '0;
        chain_s[0] = c_in;
        for (int i = 0; i < W; i++) begin
            sum[i]       = a[i] ^ b_eff_s[i] ^ chain_s[i];
            chain_s[i+1] = (a[i] & b_eff_s[i]) | (chain_s[i] & (a[i] ^ b_eff_s[i]));
        end
    end

    assign c_out = chain_s[W];
    assign c_msb = chain_s[W-1];

endmodule

// File: rtl/wide_add_sequencer.sv
// WIDTH-bit add/subtract computed one SLICE per cycle on a single shared
// ripple adder, LSB slice first, with valid/ready request and response.
module wide_add_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_sub,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_cout,
    output logic             resp_ovf,
    output logic             busy
);

    localparam int NUM_SLICES = WIDTH / SLICE;
    localparam int CW         = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    if (!slicing_ok(WIDTH, SLICE)) begin : g_bad_cfg
        $error("wide_add_sequencer: WIDTH must be a multiple of SLICE with at least two slices");
    end

    seq_state_t                         state_r;
    logic [CW-1:0]                      cnt_r;
    logic                               carry_r;
    logic                               sub_r;
    logic [NUM_SLICES-1:0][SLICE-1:0]   a_r;
    logic [NUM_SLICES-1:0][SLICE-1:0]   b_r;
    logic [NUM_SLICES-1:0][SLICE-1:0]   result_r;
    logic                               cout_r;
    logic                               ovf_r;

    logic [SLICE-1:0] slice_sum_s;
    logic             slice_cout_s;
    logic             slice_cmsb_s;
    logic             last_slice_s;
    logic             accept_s;

    assign req_ready    = (state_r == IDLE) | ((state_r == DONE) & resp_ready);
    // flush blocks acceptance even when req_ready is high.
    assign accept_s     = req_valid & req_ready & ~flush;
    assign last_slice_s = (cnt_r == CW'(NUM_SLICES - 1));

    full_adder_32bit #(
        .W (SLICE)
    ) u_slice_adder (
        .a        (a_r[cnt_r]),
        .b        (b_r[cnt_r]),
        .invert_b (sub_r),
        .c_in     (carry_r),
        .sum      (slice_sum_s),
        .c_out    (slice_cout_s),
        .c_msb    (slice_cmsb_s)
    );

    // Sequencer FSM, slice counter, carry and operand/result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            carry_r  <= 1'b0;
            sub_r    <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (flush) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            carry_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        a_r     <= req_a;
                        b_r     <= req_b;
                        sub_r   <= req_sub;
                        carry_r <= req_sub;
                        cnt_r   <= '0;
                        state_r <= RUN;
                    end else if ((state_r == DONE) && resp_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                RUN: begin
                    result_r[cnt_r] <= slice_sum_s;
                    carry_r         <= slice_cout_s;
                    if (last_slice_s) begin
                        cnt_r   <= '0;
                        cout_r  <= slice_cout_s;
                        ovf_r   <= slice_cmsb_s ^ slice_cout_s;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    carry_r <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid = (state_r == DONE);
    assign busy       = (state_r != IDLE);
    assign resp_sum   = result_r;
    assign resp_cout  = cout_r;
    assign resp_ovf   = ovf_r;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed-vector bench for wide_add_sequencer at default WIDTH=128, SLICE=32.
module tb_wide_add_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic         req_sub;
    logic         resp_valid;
    logic         resp_ready;
    logic [127:0] resp_sum;
    logic         resp_cout;
    logic         resp_ovf;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] ALL1  = {128{1'b1}};
    localparam logic [127:0] SMAX  = {1'b0, {127{1'b1}}};
    localparam logic [127:0] SMIN  = {1'b1, {127{1'b0}}};
    localparam logic [127:0] NEG2  = {{127{1'b1}}, 1'b0};
    localparam logic [127:0] MIDA  = 128'h00000000_FFFFFFFF_00000000_FFFFFFFF;
    localparam logic [127:0] MIDS  = 128'h00000000_FFFFFFFF_00000001_00000000;

    wide_add_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sub    (req_sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_ovf   (resp_ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Accept one op and advance exactly to the cycle where resp_valid must be up.
    task automatic do_op(input logic [127:0] a, input logic [127:0] b, input logic sub);
        req_a     = a;
        req_b     = b;
        req_sub   = sub;
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        req_a     = 128'h0BAD_0BAD;
        req_b     = 128'h0BAD_0BAD;
        req_sub   = ~sub;
        repeat (4) cyc();
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_a = '0; req_b = '0; req_sub = 1'b0;
        #2;
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_sum !== 128'd0) begin failures++; $display("FAIL reset_resp_sum got=%h exp=0", resp_sum); end
        checks++; if (resp_cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", resp_cout); end
        checks++; if (resp_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", resp_ovf); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_carry_chain();
        req_a = ALL1; req_b = 128'd1; req_sub = 1'b0; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin failures++; $display("FAIL chain_run_state got=busy%b/rdy%b exp=busy1/rdy0", busy, req_ready); end
        repeat (3) cyc();
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL chain_early_valid got=%b exp=0", resp_valid); end
        cyc();
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL chain_latency got=%b exp=1", resp_valid); end
        checks++; if (resp_sum !== 128'd0) begin failures++; $display("FAIL chain_sum got=%h exp=0", resp_sum); end
        checks++; if (resp_cout !== 1'b1 || resp_ovf !== 1'b0) begin failures++; $display("FAIL chain_flags got=c%b/o%b exp=c1/o0", resp_cout, resp_ovf); end
        consume();
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL chain_release got=v%b/b%b exp=v0/b0", resp_valid, busy); end
    endtask

    task automatic test_sub_borrow();
        do_op(128'd5, 128'd7, 1'b1);
        checks++; if (resp_valid !== 1'b1 || resp_sum !== NEG2) begin failures++; $display("FAIL sub_sum got=v%b/%h exp=v1/%h", resp_valid, resp_sum, NEG2); end
        checks++; if (resp_cout !== 1'b0 || resp_ovf !== 1'b0) begin failures++; $display("FAIL sub_flags got=c%b/o%b exp=c0/o0", resp_cout, resp_ovf); end
        consume();
    endtask

    task automatic test_overflow();
        do_op(SMAX, 128'd1, 1'b0);
        checks++; if (resp_sum !== SMIN) begin failures++; $display("FAIL ovf_add_sum got=%h exp=%h", resp_sum, SMIN); end
        checks++; if (resp_cout !== 1'b0 || resp_ovf !== 1'b1) begin failures++; $display("FAIL ovf_add_flags got=c%b/o%b exp=c0/o1", resp_cout, resp_ovf); end
        consume();
        do_op(SMIN, 128'd1, 1'b1);
        checks++; if (resp_sum !== SMAX) begin failures++; $display("FAIL ovf_sub_sum got=%h exp=%h", resp_sum, SMAX); end
        checks++; if (resp_cout !== 1'b1 || resp_ovf !== 1'b1) begin failures++; $display("FAIL ovf_sub_flags got=c%b/o%b exp=c1/o1", resp_cout, resp_ovf); end
        consume();
        do_op(MIDA, 128'd1, 1'b0);
        checks++; if (resp_sum !== MIDS || resp_cout !== 1'b0 || resp_ovf !== 1'b0) begin failures++; $display("FAIL mid_carry got=%h/c%b/o%b exp=%h/c0/o0", resp_sum, resp_cout, resp_ovf, MIDS); end
        consume();
    endtask

    task automatic test_back_to_back();
        do_op(128'd10, 128'd20, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (resp_valid !== 1'b1 || resp_sum !== 128'd30 || req_ready !== 1'b0) begin failures++; $display("FAIL hold_%0d got=v%b/%0d/rdy%b exp=v1/30/rdy0", i, resp_valid, resp_sum, req_ready); end
            cyc();
        end
        resp_ready = 1'b1; req_valid = 1'b1; req_a = 128'd3; req_b = 128'd4; req_sub = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", req_ready); end
        cyc();
        resp_ready = 1'b0; req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=v%b/b%b exp=v0/b1", resp_valid, busy); end
        repeat (3) cyc();
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_early got=%b exp=0", resp_valid); end
        cyc();
        checks++; if (resp_valid !== 1'b1 || resp_sum !== 128'd7) begin failures++; $display("FAIL b2b_sum got=v%b/%0d exp=v1/7", resp_valid, resp_sum); end
        consume();
    endtask

    task automatic test_flush();
        int seen;
        req_a = 128'd100; req_b = 128'd1; req_sub = 1'b0; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        repeat (2) cyc();
        flush = 1'b1; req_valid = 1'b1; req_a = 128'd9; req_b = 128'd9;
        cyc();
        flush = 1'b0; req_valid = 1'b0;
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL flush_run got=b%b/v%b/r%b exp=b0/v0/r1", busy, resp_valid, req_ready); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (resp_valid === 1'b1 || busy === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL flush_no_resp got=%0d exp=0", seen); end
        flush = 1'b1; req_valid = 1'b1;
        cyc();
        flush = 1'b0; req_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_idle_accept got=%b exp=0", busy); end
        do_op(128'd100, 128'd1, 1'b0);
        checks++; if (resp_valid !== 1'b1 || resp_sum !== 128'd101) begin failures++; $display("FAIL flush_after got=v%b/%0d exp=v1/101", resp_valid, resp_sum); end
        consume();
    endtask

    task automatic test_async_reset();
        req_a = 128'd50; req_b = 128'd60; req_sub = 1'b0; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL areset_ctrl got=b%b/v%b/r%b exp=b0/v0/r1", busy, resp_valid, req_ready); end
        checks++; if (resp_sum !== 128'd0 || resp_cout !== 1'b0 || resp_ovf !== 1'b0) begin failures++; $display("FAIL areset_data got=%h/c%b/o%b exp=0/c0/o0", resp_sum, resp_cout, resp_ovf); end
        cyc();
        #2;
        rst_n = 1'b1;
        repeat (5) cyc();
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL areset_discard got=v%b/b%b exp=v0/b0", resp_valid, busy); end
        req_a = 128'd1; req_b = 128'd2; req_sub = 1'b0; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        repeat (3) cyc();
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL areset_early got=%b exp=0", resp_valid); end
        cyc();
        checks++; if (resp_valid !== 1'b1 || resp_sum !== 128'd3) begin failures++; $display("FAIL areset_op got=v%b/%0d exp=v1/3", resp_valid, resp_sum); end
        consume();
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_sub_borrow();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
Multi-cycle controller that performs WIDTH-bit add/subtract by time-multiplexing one SLICE-bit ripple adder, one slice per cycle, LSB slice first.
- Carries the inter-slice carry in a register.
- Sits beside the execute stage as a low-area alternative to the full-width ripple adder, for wide (128-bit) operations from either issue lane.
- Uses valid/ready handshakes on request and response, plus a synchronous flush from pipeline control.

Parameters:
WIDTH, 128, operand/result width; must be an integer multiple of SLICE.
SLICE, 32, width of the shared adder slice processed per cycle.
NUM_SLICES, WIDTH/SLICE (derived, localparam), number of RUN cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort of any in-flight operation
req_valid  input  1  request present
req_ready  output  1  block can accept request this cycle
req_a  input  WIDTH  operand A
req_b  input  WIDTH  operand B
req_sub  input  1  1 = A-B (invert B, carry-in 1), 0 = A+B (carry-in 0)
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_sum  output  WIDTH  result
resp_cout  output  1  carry out of MSB (for sub: 1 = no borrow)
resp_ovf  output  1  signed overflow of MSB slice
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, slice counter=0, carry reg=0, operand/result regs=0.
  - Outputs during and after reset: resp_valid=0, resp_sum=0, resp_cout=0, resp_ovf=0, busy=0, req_ready=1.
  - Reset mid-operation discards everything; no response is produced.
- States IDLE, RUN, DONE.
- req_ready = (state==IDLE) | (state==DONE & resp_ready). Combinational from state and resp_ready only; never depends on req_valid.
- Accept = req_valid & req_ready at edge T:
  - Latch A, B and sub.
  - carry reg <= req_sub; counter <= 0; state -> RUN.
- RUN, each cycle k (counter k = 0..NUM_SLICES-1):
  - Slice k of A, and of B (inverted when sub), plus carry reg, feed the shared adder.
  - At the edge: result[k*SLICE +: SLICE] <= slice sum; carry reg <= slice cout; counter++.
  - On the edge with k = NUM_SLICES-1: state -> DONE; resp_cout <= slice cout; resp_ovf <= carry into MSB XOR carry out of MSB.
- Latency: resp_valid rises after edge T+NUM_SLICES (4 cycles at defaults). Throughput is one op per NUM_SLICES+1 cycles with back-to-back accept.
- DONE:
  - resp_valid=1; resp_sum, resp_cout and resp_ovf are held stable until resp_valid & resp_ready.
  - On handshake: if a new request is accepted the same cycle -> RUN with the new operands; else -> IDLE.
  - resp_valid is 0 in IDLE/RUN; result regs keep their last value but are only meaningful with resp_valid.
- flush (sync, highest priority after reset):
  - In any state -> IDLE next edge; resp_valid drops; carry/counter cleared.
  - A request presented the same cycle as flush is NOT accepted, even if req_ready=1 that cycle.
- Simultaneous resp handshake and flush: flush wins; the response counts as consumed.
- Counter width is $clog2(NUM_SLICES), minimum 1. The counter never wraps past NUM_SLICES-1 in RUN.
- Inputs other than handshakes are ignored outside the accept cycle.

Decomposition:
Shared package (alu_seq_pkg):
- state enum (IDLE, RUN, DONE).
- default WIDTH/SLICE constants.
- A static check that WIDTH % SLICE == 0 and NUM_SLICES >= 2.

Sub-module: a single instance of the team's SLICE-bit ripple adder (full_adder_32bit at defaults).
- Invert_B is driven from the latched sub flag.
- C_in is driven from the carry reg.
- A and B are driven from muxes selected by the counter.

FSM, counter, operand and result registers live in wide_add_sequencer itself.

Test Plan:
- Full carry chain: A=2^128-1, B=1, sub=0, accepted at T -> resp_valid at T+4, resp_sum=0, resp_cout=1, resp_ovf=0.
- Subtract with borrow: A=5, B=7, sub=1 -> resp_sum=2^128-2, resp_cout=0, resp_ovf=0.
- Signed overflow: A=0x7FFF...FFFF, B=1, add -> resp_sum=0x8000...0000, resp_ovf=1, resp_cout=0. Also A=0x8000...0000, B=1, sub -> resp_ovf=1.
- Backpressure and back-to-back:
  - Hold resp_ready=0 for 3 cycles in DONE -> outputs stable, req_ready=0.
  - Then resp_ready=1 with req_valid=1 (A=3, B=4) -> new op accepted the same cycle; resp_sum=7 four cycles later.
- Flush at RUN counter=2 with req_valid=1 -> IDLE next cycle, no resp_valid ever, request not accepted; next request completes normally.
- Async reset: drop rst_n mid-RUN between clock edges -> outputs immediately at reset values, req_ready=1; after release a fresh op completes with correct latency.
